// File: rtl/seven_segment_pkg.sv
// Segment patterns, segment type and nibble decode for the scanned display.
// SEVEN_SEGMENT_HEX_EN selects hex glyphs for nibbles 10-15; otherwise they show dark.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

`ifdef SEVEN_SEGMENT_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles are dark in BCD-only builds.
  function automatic seg_t seg_decode(input logic [3:0] nib);
    seg_t s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = HEX_EN ? SEG_A : SEG_OFF;
      4'hB: s = HEX_EN ? SEG_B : SEG_OFF;
      4'hC: s = HEX_EN ? SEG_C : SEG_OFF;
      4'hD: s = HEX_EN ? SEG_D : SEG_OFF;
      4'hE: s = HEX_EN ? SEG_E : SEG_OFF;
      4'hF: s = HEX_EN ? SEG_F : SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder around the package decode function.
module seg7_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_c_o
);

  assign seg_c_o = seg_decode(nib_i);

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit seven-segment driver: shadow value, prescaled digit scan, registered pins.
// Hex glyphs for nibbles 10-15 are enabled by defining SEVEN_SEGMENT_HEX_EN.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned LZB    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  seg_t                seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic [3:0]          nib;
  logic                dp_sel;
  logic [DIGITS-1:0]   an_sel;
  logic [DIGITS-1:0]   zero_from;
  logic                lead_blank;
  seg_t                dec_seg;

  // zero_from[i]: nibbles i..DIGITS-1 of the shadow value are all zero.
  always_comb begin : lzb_scan
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && (val_q[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  always_comb begin : digit_mux
    nib        = 4'h0;
    dp_sel     = 1'b0;
    an_sel     = '0;
    lead_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib        = val_q[4*i +: 4];
        dp_sel     = dp_q[i];
        an_sel[i]  = 1'b1;
        lead_blank = (LZB != 0) && (i != 0) && zero_from[i];
      end
    end
  end

  seg7_decode u_decode (
    .nib_i   (nib),
    .seg_c_o (dec_seg)
  );

  always_comb begin : next_state
    tick     = (pre_q == PRE_W'(DIV - 1));
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    val_d    = load ? value : val_q;
    dp_d     = load ? dp : dp_q;
    an_d     = blank ? '0 : an_sel;
    seg_d    = (blank || lead_blank) ? SEG_OFF : dec_seg;
    seg_dp_d = !blank && dp_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      val_q    <= '0;
      dp_q     <= '0;
      seg_q    <= SEG_OFF;
      seg_dp_q <= 1'b0;
      an_q     <= '0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      dp_q     <= dp_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign an     = an_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench: two scanners (LZB off/on) against an arithmetic reference of the display.
module tb_seven_segment_scan;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: edges since reset release and the shadow contents.
  int          k_m;
  logic [15:0] val_m;
  logic [3:0]  dp_m;
  logic [3:0]  e_an;
  logic [6:0]  e_seg_a, e_seg_b;
  logic        e_dp;

  always #5 clk = ~clk;

  seven_segment_scan #(.DIGITS(DIGITS), .DIV(DIV), .LZB(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg(seg_a), .seg_dp(dp_a), .an(an_a)
  );

  seven_segment_scan #(.DIGITS(DIGITS), .DIV(DIV), .LZB(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank(blank),
    .seg(seg_b), .seg_dp(dp_b), .an(an_b)
  );

  function automatic logic [6:0] ref_seg(input int n);
    case (n)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
`ifdef SEVEN_SEGMENT_HEX_EN
      10: return 7'h77;
      11: return 7'h7C;
      12: return 7'h39;
      13: return 7'h5E;
      14: return 7'h79;
      15: return 7'h71;
`endif
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_reset();
    k_m   = 0;
    val_m = '0;
    dp_m  = '0;
  endtask

  // Drive inputs, take one rising edge, derive the expected pins, then settle past the edge.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic bl);
    int dig;
    int upper;
    int nib;
    load  = ld;
    value = v;
    dp    = d;
    blank = bl;
    @(posedge clk);
    dig   = int'(k_m / DIV) % int'(DIGITS);
    upper = int'(val_m >> (4 * dig));
    nib   = upper % 16;
    if (bl) begin
      e_an = '0; e_seg_a = '0; e_seg_b = '0; e_dp = 1'b0;
    end else begin
      e_an    = 4'(1 << dig);
      e_seg_a = ref_seg(nib);
      e_seg_b = (dig > 0 && upper == 0) ? 7'h00 : ref_seg(nib);
      e_dp    = dp_m[dig];
    end
    k_m++;
    if (ld) begin
      val_m = v;
      dp_m  = d;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: an=%b/%b seg=%h/%h dp=%b/%b, expected all zero",
               an_a, an_b, seg_a, seg_b, dp_a, dp_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, '0, '0, 1'b0);
    n_checks++;
    if (an_a !== 4'b0001 || seg_a !== 7'h3F) begin
      n_fail++;
      $display("FAIL first_edge: an=%b seg=%h, expected an=0001 seg=3f", an_a, seg_a);
    end
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}) begin
        n_fail++;
        $display("FAIL idle_scan k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  task automatic test_pattern(input string name, input logic [15:0] v, input logic [3:0] d);
    cycle(1'b1, v, d, 1'b0);
    for (int c = 0; c < 14; c++) begin
      cycle(1'b0, $urandom, 4'($urandom), 1'b0);
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}) begin
        n_fail++;
        $display("FAIL %s k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 name, k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  task automatic test_blank();
    for (int c = 0; c < 18; c++) begin
      cycle(1'b0, '0, '0, (c >= 4 && c < 9));
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}) begin
        n_fail++;
        $display("FAIL blank k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 30; c++) begin
      cycle(1'b1, 16'($urandom), 4'($urandom), 1'b0);
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 300; c++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
      cycle($urandom_range(0, 3) == 0, v, 4'($urandom), $urandom_range(0, 7) == 0);
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}
          || !$onehot0(an_a) || !$onehot0(an_b)) begin
        n_fail++;
        $display("FAIL random k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, '0, '0, 1'b0);
    load  = 1'b1;
    value = 16'h8888;
    dp    = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: an=%b/%b seg=%h/%h dp=%b/%b, expected all zero",
               an_a, an_b, seg_a, seg_b, dp_a, dp_b);
    end
    load = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 7; c++) begin
      cycle(1'b0, '0, '0, 1'b0);
      n_checks++;
      if ({an_a, seg_a, dp_a} !== {e_an, e_seg_a, e_dp} || {an_b, seg_b, dp_b} !== {e_an, e_seg_b, e_dp}
          || (c == 0 && (an_a !== 4'b0001 || seg_a !== 7'h3F))) begin
        n_fail++;
        $display("FAIL reset_mid_restart k=%0d: an=%b/%b seg=%h/%h dp=%b/%b, expected an=%b seg=%h/%h dp=%b",
                 k_m, an_a, an_b, seg_a, seg_b, dp_a, dp_b, e_an, e_seg_a, e_seg_b, e_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern("load_1234", 16'h1234, 4'b0100);
    test_pattern("hex_00a5", 16'h00A5, 4'b0000);
    test_pattern("lzb_0070", 16'h0070, 4'b1010);
    test_blank();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Multiplexed N-digit seven-segment display driver, the parametrised successor of the single-digit decoder. Holds a DIGITS-wide packed nibble value in a shadow register loaded by strobe, scans the digits one at a time at a programmable refresh rate, and drives shared segment lines plus one-hot digit enables. Sits between the datapath producing BCD/hex values and the board display pins.

## Interface
- `DIGITS`, 4, number of digits, at least 1.
- `DIV`, 1000, clock cycles each digit is lit (dwell), at least 1.
- `LZB`, 0, 1 enables leading-zero blanking.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load` in 1: capture `value` and `dp` into the shadow registers.
- `value` in 4*DIGITS: packed nibbles; digit 0 = `value[3:0]` (least significant).
- `dp` in DIGITS: decimal point per digit.
- `blank` in 1: force display dark.
- `seg` out 7: {g,f,e,d,c,b,a}, active-high, registered.
- `seg_dp` out 1: decimal point segment, active-high, registered.
- `an` out DIGITS: one-hot digit enable, active-high, registered.

## Operation
- Shadow registers `val_q`/`dp_q` update on any edge with `load`=1; otherwise they hold.
- Prescaler `pre` counts 0..DIV-1 and wraps; tick = (`pre`==DIV-1). DIV=1 means tick every cycle.
- Digit index `idx` advances on tick, DIGITS-1 wraps to 0. DIGITS=1 means `idx` is constantly 0.
- Every edge registers: `an` = 1<<`idx`; `seg` = decode(`val_q[4*idx+:4]`); `seg_dp` = `dp_q[idx]`.
- Decode (hex, active-high): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles 10-15 decode per Configuration.
- LZB=1: digit i>0 shows `seg`=0 when nibbles i..DIGITS-1 are all zero. `an` and `seg_dp` are unaffected. Digit 0 is never blanked.
- `blank`=1: next edge gives `an`=0, `seg`=0, `seg_dp`=0. Prescaler, `idx`, and loads continue normally.

## Timing
- Reset (async, immediate): `seg`=0, `seg_dp`=0, `an`=0, `pre`=0, `idx`=0, `val_q`=0, `dp_q`=0.
- First edge after `rst_n` rises: `an`=0001, `seg`=3F.
- Load latency: value captured at edge E is visible on `seg` at edge E+1 (if its digit is being scanned).
- Dwell: each digit is lit exactly DIV cycles. A full frame is DIGITS*DIV cycles.
- `load` coincident with tick: the new `idx` and new `val_q` both take effect together at the next edge. There is no mixed output.
- `blank` deassert: normal output at the next edge, continuing from the current `idx`. There is no resync.
- `rst_n` asserted mid-dwell: all state clears at once. The scan restarts at digit 0 with a full DIV dwell.
- `an` is always one-hot or zero; never more than one bit is set.

## Configuration
- `SEVEN_SEGMENT_HEX_EN` defined: nibbles 10-15 decode to A=77, b=7C, C=39, d=5E, E=79, F=71.
- Not defined: nibbles 10-15 decode to `seg`=0 (blank digit, BCD-only mode).
- `seg_dp` and `an` are unaffected by the macro in either case.

## Structure
- Package `seven_segment_pkg` holds:
  - segment-pattern localparams (`SEG_0`..`SEG_F`, `SEG_OFF`);
  - the 7-bit segment typedef;
  - the macro-dependent decode function.
- Sub-module `seg7_decode`: combinational 4-bit to 7-bit decoder wrapping the package function, instantiated once on the muxed nibble.
- The top level owns the prescaler, index counter, shadow registers, LZB logic, and output registers.

## Test plan
- Reset then release, DIGITS=4, DIV=3, no load:
  - `an` cycles 0001, 0010, 0100, 1000, 0001;
  - each value is held 3 cycles;
  - `seg`=3F throughout.
- `load` with `value`=16'h1234, `dp`=4'b0100:
  - `an`=0001 gives `seg`=66;
  - `an`=0010 gives `seg`=4F;
  - `an`=0100 gives `seg`=5B and `seg_dp`=1;
  - `an`=1000 gives `seg`=06.
- `value`=16'h00A5:
  - with the macro defined, digit 1 gives `seg`=77;
  - without the macro, digit 1 gives `seg`=00;
  - digit 0 gives `seg`=6D in both cases.
- LZB=1, `value`=16'h0070: digits 3 and 2 give `seg`=00, digit 1 gives 07, digit 0 gives 3F.
- `blank`=1 for 5 cycles mid-scan: `an`=0 and `seg`=0 on the following edge. After release, the scan resumes at the digit the counter has reached.
- Assert `rst_n`=0 mid-dwell with `load` pending:
  - all outputs go to 0 asynchronously;
  - after release, `an`=0001 and `seg`=3F, because `val_q` has been cleared.
